// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: NOP encoding and FSM states.
package instr_fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one imem read per accepted PC, holds the
// fetched word for decode, and handles flush/stall and misaligned addresses.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int OPD_WIDTH = 32,
  parameter int PC_WIDTH  = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PC_WIDTH-1:0]  pc_in,
  input  logic                 pc_valid,
  input  logic                 flush,
  input  logic                 stall,
  output logic                 imem_req,
  output logic [PC_WIDTH-1:0]  imem_addr,
  input  logic                 imem_ack,
  input  logic [OPD_WIDTH-1:0] imem_rdata,
  output logic [OPD_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]  instr_pc,
  output logic                 instr_valid,
  output logic                 fetch_err
);

  state_t                 r_state, w_state_nxt;
  logic                   r_req, w_req_nxt;
  logic [PC_WIDTH-1:0]    r_addr, w_addr_nxt;
  logic [OPD_WIDTH-1:0]   r_instr, w_instr_nxt;
  logic [PC_WIDTH-1:0]    r_pc, w_pc_nxt;
  logic                   r_valid, w_valid_nxt;
  logic                   r_err, w_err_nxt;
  logic                   w_accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_instr <= OPD_WIDTH'(NOP_INSTR);
      r_pc    <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_addr  <= w_addr_nxt;
      r_instr <= w_instr_nxt;
      r_pc    <= w_pc_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_addr_nxt  = r_addr;
    w_instr_nxt = r_instr;
    w_pc_nxt    = r_pc;
    w_valid_nxt = r_valid;
    w_err_nxt   = r_err;
    w_accept    = 1'b0;

    unique case (r_state)
      IDLE: w_accept = 1'b1;
      FETCH: begin
        if (imem_ack) begin
          w_req_nxt = 1'b0;
          if (flush) begin
            w_state_nxt = IDLE;
          end else begin
            w_instr_nxt = imem_rdata;
            w_pc_nxt    = r_addr;
            w_valid_nxt = 1'b1;
            w_err_nxt   = 1'b0;
            w_state_nxt = HOLD;
          end
        end else if (flush) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_ack) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (flush || !stall) begin
          w_valid_nxt = 1'b0;
          w_err_nxt   = 1'b0;
          w_state_nxt = IDLE;
          w_accept    = !flush;
        end
      end
    endcase

    // IDLE acceptance is shared with HOLD-consume so a new PC lands back-to-back.
    if (w_accept && pc_valid && !flush) begin
      if (pc_in[1:0] == 2'b00) begin
        w_addr_nxt  = pc_in;
        w_req_nxt   = 1'b1;
        w_state_nxt = FETCH;
      end else begin
        w_instr_nxt = OPD_WIDTH'(NOP_INSTR);
        w_pc_nxt    = pc_in;
        w_valid_nxt = 1'b1;
        w_err_nxt   = 1'b1;
        w_state_nxt = HOLD;
      end
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign instr       = r_instr;
  assign instr_pc    = r_pc;
  assign instr_valid = r_valid;
  assign fetch_err   = r_err;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: stimulus queues expected instructions,
// a negedge monitor pops and compares each instruction presented to decode.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic        clk;
  logic        rst;
  logic [11:0] pc_in;
  logic        pc_valid;
  logic        flush;
  logic        stall;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [11:0] instr_pc;
  logic        instr_valid;
  logic        fetch_err;

  typedef struct {
    logic [31:0] instr;
    logic [11:0] pc;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic seen   = 1'b0;

  instr_fetch #(.OPD_WIDTH(32), .PC_WIDTH(12)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_valid(pc_valid),
    .flush(flush), .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_instr(input logic [31:0] i, input logic [11:0] p, input logic e);
    exp_t x;
    x.instr = i;
    x.pc    = p;
    x.err   = e;
    exp_q.push_back(x);
  endtask

  // Monitor: one pop per instruction presented; a held instruction is compared once.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
      end else begin
        if (instr_valid && !seen) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_instr_valid", {63'd0, instr_valid}, 64'd0);
          end else begin
            x = exp_q.pop_front();
            chk("mon_instr", {32'd0, instr}, {32'd0, x.instr});
            chk("mon_instr_pc", {52'd0, instr_pc}, {52'd0, x.pc});
            chk("mon_fetch_err", {63'd0, fetch_err}, {63'd0, x.err});
          end
          seen = 1'b1;
        end
        if (!instr_valid || !stall || flush) seen = 1'b0;
      end
    end
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    rst = 1'b0; pc_in = '0; pc_valid = 1'b0; flush = 1'b0; stall = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0;
    #2 rst = 1'b1;
    #1;
    chk("rst_req",   {63'd0, imem_req}, 64'd0);
    chk("rst_addr",  {52'd0, imem_addr}, 64'd0);
    chk("rst_instr", {32'd0, instr}, 64'h13);
    chk("rst_pc",    {52'd0, instr_pc}, 64'd0);
    chk("rst_valid", {63'd0, instr_valid}, 64'd0);
    chk("rst_err",   {63'd0, fetch_err}, 64'd0);
    step(); step();
    rst = 1'b0;

    // Minimum-latency fetch with same-cycle ack
    pc_in = 12'h004; pc_valid = 1'b1;
    expect_instr(32'h0050_0093, 12'h004, 1'b0);
    step();
    pc_valid = 1'b0;
    chk("t1_req", {63'd0, imem_req}, 64'd1);
    chk("t1_addr", {52'd0, imem_addr}, 64'h004);
    imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
    step();
    imem_ack = 1'b0;
    chk("t1_valid_2cyc", {63'd0, instr_valid}, 64'd1);
    chk("t1_req_drop", {63'd0, imem_req}, 64'd0);
    step();
    chk("t1_consumed", {63'd0, instr_valid}, 64'd0);

    // Ack delayed three cycles
    pc_in = 12'h010; pc_valid = 1'b1;
    expect_instr(32'h00A0_0113, 12'h010, 1'b0);
    step();
    pc_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_req_held", {63'd0, imem_req}, 64'd1);
      chk("t2_addr_held", {52'd0, imem_addr}, 64'h010);
      chk("t2_no_valid", {63'd0, instr_valid}, 64'd0);
      step();
    end
    chk("t2_req_before_ack", {63'd0, imem_req}, 64'd1);
    imem_ack = 1'b1; imem_rdata = 32'h00A0_0113;
    step();
    imem_ack = 1'b0;
    chk("t2_valid", {63'd0, instr_valid}, 64'd1);

    // Stall holds the instruction; release with back-to-back fetch
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_stall_instr", {32'd0, instr}, 64'h00A0_0113);
      chk("t3_stall_pc", {52'd0, instr_pc}, 64'h010);
      chk("t3_stall_valid", {63'd0, instr_valid}, 64'd1);
    end
    stall = 1'b0; pc_in = 12'h008; pc_valid = 1'b1;
    expect_instr(32'h0080_0193, 12'h008, 1'b0);
    step();
    pc_valid = 1'b0;
    chk("t3_b2b_req", {63'd0, imem_req}, 64'd1);
    chk("t3_b2b_addr", {52'd0, imem_addr}, 64'h008);
    chk("t3_b2b_valid", {63'd0, instr_valid}, 64'd0);
    imem_ack = 1'b1; imem_rdata = 32'h0080_0193;
    step();
    imem_ack = 1'b0;
    step();

    // Flush in second FETCH cycle, ack arrives later and is discarded
    pc_in = 12'h020; pc_valid = 1'b1;
    step();
    pc_valid = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t4_drain_req", {63'd0, imem_req}, 64'd1);
    chk("t4_drain_state", {62'd0, dut.r_state}, {62'd0, DRAIN});
    step();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    chk("t4_req_drop", {63'd0, imem_req}, 64'd0);
    chk("t4_idle", {62'd0, dut.r_state}, {62'd0, IDLE});
    step();
    chk("t4_no_valid", {63'd0, instr_valid}, 64'd0);

    // Flush coinciding with ack
    pc_in = 12'h030; pc_valid = 1'b1;
    step();
    pc_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1234_5678; flush = 1'b1;
    step();
    imem_ack = 1'b0; flush = 1'b0;
    chk("t5_req", {63'd0, imem_req}, 64'd0);
    chk("t5_valid", {63'd0, instr_valid}, 64'd0);
    chk("t5_idle", {62'd0, dut.r_state}, {62'd0, IDLE});

    // Misaligned PC
    pc_in = 12'h006; pc_valid = 1'b1;
    expect_instr(32'h0000_0013, 12'h006, 1'b1);
    step();
    pc_valid = 1'b0;
    chk("t6_no_req", {63'd0, imem_req}, 64'd0);
    chk("t6_valid", {63'd0, instr_valid}, 64'd1);
    chk("t6_err", {63'd0, fetch_err}, 64'd1);
    step();
    chk("t6_err_clear", {63'd0, fetch_err}, 64'd0);

    // Flush in HOLD beats stall and ignores pc_valid
    pc_in = 12'h040; pc_valid = 1'b1;
    expect_instr(32'h1111_1111, 12'h040, 1'b0);
    step();
    pc_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
    step();
    imem_ack = 1'b0; stall = 1'b1; flush = 1'b1; pc_in = 12'h044; pc_valid = 1'b1;
    step();
    stall = 1'b0; flush = 1'b0; pc_valid = 1'b0;
    chk("t7_valid", {63'd0, instr_valid}, 64'd0);
    chk("t7_req", {63'd0, imem_req}, 64'd0);
    chk("t7_idle", {62'd0, dut.r_state}, {62'd0, IDLE});

    // Asynchronous reset mid-FETCH
    pc_in = 12'h050; pc_valid = 1'b1;
    step();
    pc_valid = 1'b0;
    chk("t8_req_pre", {63'd0, imem_req}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t8_req_async", {63'd0, imem_req}, 64'd0);
    chk("t8_valid_async", {63'd0, instr_valid}, 64'd0);
    chk("t8_addr_async", {52'd0, imem_addr}, 64'd0);
    step();
    rst = 1'b0;
    step(); step();
    chk("t8_idle_after", {62'd0, dut.r_state}, {62'd0, IDLE});
    chk("t8_no_req_after", {63'd0, imem_req}, 64'd0);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
